load_unit: RTL and testbench

- Multi-cycle load-word (lw) datapath block; the read-side counterpart of the store path.
- Accepts an I-type load instruction plus base register value.
- Computes the effective address and issues a handshaked memory read.
- Writes the returned word back to the register file through RegWrite/Write_reg/Write_data.
- Sits between instruction decode/register read and the data memory/register file write port.

---
 rtl/load_unit.sv | 153 +++++++++++++++
 tb/tb_load_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// Multi-cycle load-word unit: effective address, handshaked memory read, register write-back.
// Optional byte loads (lb/lbu) are enabled by defining LOAD_BYTE_EN.
//   state | meaning
//   IDLE  | waiting for a load instruction
//   ADDR  | effective address valid; misaligned loads fault here
//   MEM   | MemRead asserted, waiting for Mem_ready or timeout
//   WB    | register-file write-back, done pulse
module load_unit #(
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [5:0] LW_OPCODE   = 6'b100011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  input  logic [31:0] Read_data1,
  output logic        busy,
  output logic [31:0] ALU_result,
  output logic        MemRead,
  input  logic        Mem_ready,
  input  logic [31:0] Mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  Write_reg,
  output logic [31:0] Write_data,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, ADDR, MEM, WB} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [4:0]  rt_q;
  logic [5:0]  opcode;
  logic [31:0] eff_addr;
  logic        is_load;
  logic        is_byte;
  logic        misalign;
  logic [31:0] wb_data;

  assign opcode   = instruction[31:26];
  assign eff_addr = Read_data1 + {{16{instruction[15]}}, instruction[15:0]};

`ifdef LOAD_BYTE_EN
  localparam logic [5:0] LB_OPCODE  = 6'b100000;
  localparam logic [5:0] LBU_OPCODE = 6'b100100;

  logic       byte_q;
  logic       signed_q;
  logic [7:0] lane;

  assign is_byte = (opcode == LB_OPCODE) || (opcode == LBU_OPCODE);
  assign is_load = (opcode == LW_OPCODE) || is_byte;

  always_comb begin
    lane = Mem_rdata[7:0];
    case (ALU_result[1:0])
      2'd1:    lane = Mem_rdata[15:8];
      2'd2:    lane = Mem_rdata[23:16];
      2'd3:    lane = Mem_rdata[31:24];
      default: lane = Mem_rdata[7:0];
    endcase
    wb_data = Mem_rdata;
    if (byte_q)
      wb_data = signed_q ? {{24{lane[7]}}, lane} : {24'h0, lane};
  end
`else
  assign is_byte = 1'b0;
  assign is_load = (opcode == LW_OPCODE);
  assign wb_data = Mem_rdata;
`endif

  assign misalign = !is_byte && (eff_addr[1:0] != 2'b00);

  // The address is formed at accept so ALU_result and a misalign fault are visible during ADDR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rt_q       <= '0;
      busy       <= 1'b0;
      ALU_result <= '0;
      MemRead    <= 1'b0;
      RegWrite   <= 1'b0;
      Write_reg  <= '0;
      Write_data <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
`ifdef LOAD_BYTE_EN
      byte_q     <= 1'b0;
      signed_q   <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      fault    <= 1'b0;
      RegWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && is_load) begin
            state      <= ADDR;
            busy       <= 1'b1;
            rt_q       <= instruction[20:16];
            ALU_result <= eff_addr;
            done       <= misalign;
            fault      <= misalign;
`ifdef LOAD_BYTE_EN
            byte_q     <= is_byte;
            signed_q   <= (opcode == LB_OPCODE);
`endif
          end
        end
        ADDR: begin
          // fault is only ever high in ADDR for a misaligned address
          if (fault) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= MEM;
            MemRead  <= 1'b1;
            wait_cnt <= '0;
          end
        end
        MEM: begin
          if (Mem_ready) begin
            state      <= WB;
            MemRead    <= 1'b0;
            Write_reg  <= rt_q;
            Write_data <= wb_data;
            RegWrite   <= (rt_q != 5'd0);
            done       <= 1'b1;
          end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            MemRead <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with MEM_TIMEOUT=8; byte-load checks follow LOAD_BYTE_EN.
module tb_load_unit;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] Read_data1;
  logic        busy;
  logic [31:0] ALU_result;
  logic        MemRead;
  logic        Mem_ready;
  logic [31:0] Mem_rdata;
  logic        RegWrite;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;
  logic        done;
  logic        fault;

  int total = 0;
  int bad   = 0;
  int mr_cnt = 0;
  int rw_cnt = 0;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;

  load_unit #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .Read_data1(Read_data1), .busy(busy), .ALU_result(ALU_result), .MemRead(MemRead),
    .Mem_ready(Mem_ready), .Mem_rdata(Mem_rdata), .RegWrite(RegWrite),
    .Write_reg(Write_reg), .Write_data(Write_data), .done(done), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    if (MemRead)  mr_cnt++;
    if (RegWrite) rw_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] off,
                       input logic [31:0] base);
    instr_valid = 1'b1;
    instruction = {op, 5'd1, rt, off};
    Read_data1  = base;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instruction = '0; Read_data1 = '0;
    Mem_ready = 1'b0; Mem_rdata = '0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu", ALU_result, 32'd0);
    check("rst_memread", 32'(MemRead), 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_wreg", 32'(Write_reg), 32'd0);
    check("rst_wdata", Write_data, 32'd0);
    check("rst_done_fault", {30'd0, done, fault}, 32'd0);
    reset = 1'b0;

    // aligned load, data ready on first MEM cycle (Mem_ready high during ADDR is ignored)
    mr_cnt = 0; rw_cnt = 0;
    issue(LW, 5'd9, 16'h0004, 32'h0);
    check("a_addr_busy", 32'(busy), 32'd1);
    check("a_addr_alu", ALU_result, 32'h4);
    check("a_addr_done", 32'(done), 32'd0);
    Mem_ready = 1'b1; Mem_rdata = 32'h12345678;
    tick();
    check("a_mem_memread", 32'(MemRead), 32'd1);
    tick();
    check("a_wb_regwrite", 32'(RegWrite), 32'd1);
    check("a_wb_wreg", 32'(Write_reg), 32'd9);
    check("a_wb_wdata", Write_data, 32'h12345678);
    check("a_wb_done_fault", {30'd0, done, fault}, 32'b10);
    check("a_wb_memread", 32'(MemRead), 32'd0);
    Mem_ready = 1'b0;
    tick();
    check("a_idle_busy", 32'(busy), 32'd0);
    check("a_idle_pulses", {29'd0, RegWrite, done, fault}, 32'd0);
    check("a_hold_wdata", Write_data, 32'h12345678);
    check("a_memread_cycles", 32'(mr_cnt), 32'd1);

    // negative offset with three wait states
    mr_cnt = 0;
    issue(LW, 5'd3, 16'hFFFC, 32'h20);
    check("n_alu", ALU_result, 32'h1C);
    tick(); tick(); tick(); tick();
    check("n_wait_memread", 32'(MemRead), 32'd1);
    check("n_wait_alu", ALU_result, 32'h1C);
    Mem_ready = 1'b1; Mem_rdata = 32'hABCDEF01;
    tick();
    Mem_ready = 1'b0;
    check("n_wb_wdata", Write_data, 32'hABCDEF01);
    check("n_wb_regwrite", 32'(RegWrite), 32'd1);
    check("n_wb_wreg", 32'(Write_reg), 32'd3);
    check("n_memread_cycles", 32'(mr_cnt), 32'd4);
    tick();

    // misaligned address faults in ADDR
    mr_cnt = 0; rw_cnt = 0;
    issue(LW, 5'd5, 16'h0000, 32'h1);
    check("m_done_fault", {30'd0, done, fault}, 32'b11);
    check("m_busy", 32'(busy), 32'd1);
    tick();
    check("m_idle_busy", 32'(busy), 32'd0);
    check("m_idle_pulses", {30'd0, done, fault}, 32'd0);
    tick();
    check("m_no_memread", 32'(mr_cnt), 32'd0);
    check("m_no_regwrite", 32'(rw_cnt), 32'd0);

    // timeout with Mem_ready held low
    mr_cnt = 0; rw_cnt = 0;
    issue(LW, 5'd7, 16'h0010, 32'h100);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) break;
    end
    check("t_done_fault", {30'd0, done, fault}, 32'b11);
    check("t_memread_cycles", 32'(mr_cnt), 32'd8);
    check("t_regwrite", 32'(rw_cnt), 32'd0);
    check("t_busy", 32'(busy), 32'd0);
    check("t_memread_low", 32'(MemRead), 32'd0);
    tick();

    // rt = 0 suppresses RegWrite; an instr_valid pulse while busy is dropped
    rw_cnt = 0;
    Mem_ready = 1'b1; Mem_rdata = 32'h55AA55AA;
    issue(LW, 5'd0, 16'h0000, 32'h40);
    issue(LW, 5'd9, 16'h0008, 32'h0);
    tick();
    Mem_ready = 1'b0;
    check("z_done", 32'(done), 32'd1);
    check("z_regwrite", 32'(rw_cnt), 32'd0);
    check("z_wreg", 32'(Write_reg), 32'd0);
    check("z_wdata", Write_data, 32'h55AA55AA);
    tick();
    tick();
    check("z_not_queued_busy", 32'(busy), 32'd0);
    check("z_not_queued_alu", ALU_result, 32'h40);

    // store opcode is ignored in IDLE
    issue(SW, 5'd6, 16'h0004, 32'h200);
    check("s_busy", 32'(busy), 32'd0);
    check("s_alu", ALU_result, 32'h40);
    tick();

    // reset in MEM drops the transaction
    rw_cnt = 0;
    issue(LW, 5'd4, 16'h0000, 32'h80);
    tick();
    check("r_memread", 32'(MemRead), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_memread_low", 32'(MemRead), 32'd0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_alu", ALU_result, 32'd0);
    check("r_outputs", {27'd0, Write_reg}, 32'd0);
    check("r_wdata", Write_data, 32'd0);
    Mem_ready = 1'b1; Mem_rdata = 32'hDEADBEEF;
    tick(); tick(); tick();
    Mem_ready = 1'b0;
    check("r_no_regwrite", 32'(rw_cnt), 32'd0);
    check("r_idle_busy", 32'(busy), 32'd0);

`ifdef LOAD_BYTE_EN
    // lb / lbu at address 5 select byte lane 1 (0x80)
    Mem_ready = 1'b1; Mem_rdata = 32'h000080FF;
    issue(LB, 5'd2, 16'h0000, 32'h5);
    check("b_lb_nofault", 32'(fault), 32'd0);
    tick(); tick();
    check("b_lb_wdata", Write_data, 32'hFFFFFF80);
    check("b_lb_regwrite", 32'(RegWrite), 32'd1);
    tick();
    issue(LBU, 5'd2, 16'h0000, 32'h5);
    tick(); tick();
    check("b_lbu_wdata", Write_data, 32'h00000080);
    Mem_ready = 1'b0;
    tick();
`else
    issue(LB, 5'd2, 16'h0000, 32'h5);
    check("b_lb_ignored", 32'(busy), 32'd0);
    issue(LBU, 5'd2, 16'h0000, 32'h5);
    check("b_lbu_ignored", 32'(busy), 32'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
